apb_bridge_ctrl: RTL
====================

APB_BRIDGE_CTRL -- requirements
Module: apb_bridge_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, APB/AHB address width.
REQ-002 Parameter DATA_W, default 32, read/write data width.
REQ-003 Parameter NSLV, default 3, number of APB slaves, which is also the Pselx width.
REQ-004 Parameter TIMEOUT, default 16, maximum ACCESS cycles before forced error; 0 disables the timeout.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock; rst  in  1  asynchronous reset, active low.
REQ-006 Ports SHALL be, per line name/direction/width/meaning:
- valid  in  1  AHB transfer request, qualified by Hreadyout.
- Hwrite  in  1  1 = write.
- Haddr  in  ADDR_W  address phase address.
- Hwdata  in  DATA_W  write data, valid in the data phase.
- tempselx  in  NSLV  one-hot slave select decoded from Haddr.
- Prdata  in  DATA_W  APB read data.
- Pready  in  1  APB slave ready.
- Pslverr  in  1  APB slave error.
- Paddr  out  ADDR_W  APB address.
- Pwdata  out  DATA_W  APB write data.
- Pwrite  out  1  APB direction.
- Pselx  out  NSLV  APB one-hot select.
- Penable  out  1  APB enable.
- Hreadyout  out  1  AHB ready.
- Hresp  out  1  AHB error response.
- Hrdata  out  DATA_W  AHB read data.

Function
REQ-007 The block SHALL implement states IDLE, WWAIT, SETUP, ACCESS, ERR1 and ERR2, with all outputs driven from registers.
REQ-008 In IDLE the block SHALL accept a transfer when valid=1, latching Haddr, Hwrite and tempselx on that edge.
- REQ-009 Accepted read with a legal select: IDLE->SETUP.
- REQ-010 Accepted write with a legal select: IDLE->WWAIT. WWAIT SHALL capture Hwdata, then go to SETUP.
- REQ-011 Select illegal (tempselx zero or not one-hot): IDLE->ERR1, with no APB access.
REQ-012 SETUP SHALL drive Pselx=latched select and Penable=0, then go unconditionally to ACCESS; Pready is ignored in SETUP.
REQ-013 ACCESS SHALL drive Penable=1 and keep Pselx, Paddr, Pwrite and Pwdata stable.
- Pready=1 and Pslverr=0: go to IDLE, and load Hrdata<=Prdata on a read.
- Pready=1 and Pslverr=1: go to ERR1.
- Pready=0: stay in ACCESS.
REQ-014 With TIMEOUT>0, ACCESS lasting TIMEOUT cycles with Pready=0 SHALL go to ERR1; Pready=1 in the final counted cycle takes priority over the timeout.
REQ-015 ERR1 SHALL drive Hresp=1 and Hreadyout=0; ERR2 SHALL drive Hresp=1 and Hreadyout=1, then go to IDLE.
REQ-016 Hreadyout SHALL be 1 only in IDLE and ERR2. Hresp SHALL be 1 only in ERR1 and ERR2.
REQ-017 Pselx and Penable SHALL be 0 outside SETUP and ACCESS. Paddr, Pwdata, Pwrite and Hrdata SHALL hold their last value when not being updated.
REQ-018 Latency with Pready already high SHALL be:
- Read accepted at cycle T: SETUP at T+1, ACCESS at T+2, Hreadyout=1 with valid Hrdata at T+3.
- Write accepted at T: completes with Hreadyout=1 at T+4.
REQ-019 Back-to-back transfers SHALL be supported: valid=1 in the completion IDLE cycle is accepted in that same cycle.
REQ-020 Each wait state (Pready=0) SHALL extend ACCESS, and Hreadyout=0, by exactly one cycle.

Reset
REQ-021 rst=0 SHALL asynchronously force the state to IDLE and set Paddr=0, Pwdata=0, Pwrite=0, Pselx=0, Penable=0, Hresp=0, Hrdata=0, Hreadyout=1, and the timeout count to 0.
REQ-022 A reset asserted during SETUP or ACCESS SHALL drop Pselx and Penable immediately, without waiting for a clock edge; the abandoned transfer is not completed.

Structure
REQ-023 The state encodings and the default parameter values SHALL live in a shared package/include, apb_bridge_pkg.
REQ-024 The timeout counter SHALL be a sub-module, apb_timeout_cnt, with clk, rst, clear, enable and an expired output, sized $clog2(TIMEOUT+1).

Verification
REQ-025 The bench SHALL cover the following directed scenarios (default parameters unless stated):
- Read of Haddr=0x10 with tempselx=001, Prdata=0xDEADBEEF and Pready=1 -> Pselx=001 at T+1, Penable=1 at T+2, Hreadyout=1 and Hrdata=0xDEADBEEF at T+3.
- Write of Haddr=0x20 with Hwdata=0x12345678 and Pready=1 -> Pwdata=0x12345678 and Pwrite=1 in SETUP and ACCESS, Hreadyout=1 at T+4.
- Read with Pready held low for 3 cycles -> ACCESS lasts 4 cycles, Hreadyout low for 5 cycles.
- Pslverr=1 with Pready=1 -> Hresp=1/Hreadyout=0 for one cycle, then Hresp=1/Hreadyout=1, then IDLE.
- tempselx=000, and separately tempselx=011 -> two-cycle error response with Pselx never asserted.
- Pready stuck at 0 with TIMEOUT=4 -> ERR1 after 4 ACCESS cycles; separately, rst asserted mid-ACCESS -> Pselx=0, Penable=0 and Hreadyout=1 before the next clock edge.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared FSM encoding and default parameters for the AHB-to-APB bridge
package apb_bridge_pkg;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NSLV    = 3;
  localparam int DEF_TIMEOUT = 16;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WWAIT  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } state_t;
endpackage

// File: rtl/apb_bridge_ctrl_if.sv
// apb_bridge_ctrl_if: AHB-side request and APB-side bus signals of the bridge
interface apb_bridge_ctrl_if
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NSLV   = DEF_NSLV
);
  logic              valid;
  logic              Hwrite;
  logic [ADDR_W-1:0] Haddr;
  logic [DATA_W-1:0] Hwdata;
  logic [NSLV-1:0]   tempselx;
  logic [DATA_W-1:0] Prdata;
  logic              Pready;
  logic              Pslverr;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              Pwrite;
  logic [NSLV-1:0]   Pselx;
  logic              Penable;
  logic              Hreadyout;
  logic              Hresp;
  logic [DATA_W-1:0] Hrdata;
  modport master (
    input  valid, Hwrite, Haddr, Hwdata, tempselx, Prdata, Pready, Pslverr,
    output Paddr, Pwdata, Pwrite, Pselx, Penable, Hreadyout, Hresp, Hrdata
  );
  modport slave (
    output valid, Hwrite, Haddr, Hwdata, tempselx, Prdata, Pready, Pslverr,
    input  Paddr, Pwdata, Pwrite, Pselx, Penable, Hreadyout, Hresp, Hrdata
  );
endinterface

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts ACCESS cycles; expired flags the last allowed cycle
module apb_timeout_cnt
  import apb_bridge_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] cnt;
  // expired is high during the TIMEOUT-th counted cycle, so the FSM can still honour Pready there
  assign expired = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/apb_bridge_ctrl.sv
// apb_bridge_ctrl: AHB-to-APB bridge FSM with registered outputs and ACCESS timeout
module apb_bridge_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NSLV    = DEF_NSLV,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  apb_bridge_ctrl_if.master bus
);
  state_t            st, nxt;
  logic [NSLV-1:0]   sel;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q, hrdata_q;
  logic [NSLV-1:0]   pselx_q;
  logic              pwrite_q, penable_q, hready_q, hresp_q;
  logic              legal, accept, expired;
  assign legal  = (bus.tempselx != '0) && ((bus.tempselx & (bus.tempselx - NSLV'(1))) == '0);
  assign accept = (st == IDLE) && bus.valid;
  assign bus.Paddr     = paddr_q;
  assign bus.Pwdata    = pwdata_q;
  assign bus.Pwrite    = pwrite_q;
  assign bus.Pselx     = pselx_q;
  assign bus.Penable   = penable_q;
  assign bus.Hreadyout = hready_q;
  assign bus.Hresp     = hresp_q;
  assign bus.Hrdata    = hrdata_q;
  apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (st != ACCESS),
    .enable (st == ACCESS),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = !bus.valid ? IDLE : !legal ? ERR1 : bus.Hwrite ? WWAIT : SETUP;
      WWAIT:   nxt = SETUP;
      SETUP:   nxt = ACCESS;
      ACCESS:  nxt = bus.Pready ? (bus.Pslverr ? ERR1 : IDLE) : expired ? ERR1 : ACCESS;
      ERR1:    nxt = ERR2;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so each one is a flop that matches the state it reflects
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sel       <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      pselx_q   <= '0;
      penable_q <= 1'b0;
      hready_q  <= 1'b1;
      hresp_q   <= 1'b0;
      hrdata_q  <= '0;
    end else begin
      if (accept) begin
        sel      <= bus.tempselx;
        paddr_q  <= bus.Haddr;
        pwrite_q <= bus.Hwrite;
      end
      if (st == WWAIT) pwdata_q <= bus.Hwdata;
      if (st == ACCESS && bus.Pready && !bus.Pslverr && !pwrite_q) hrdata_q <= bus.Prdata;
      pselx_q   <= (nxt == SETUP || nxt == ACCESS) ? (accept ? bus.tempselx : sel) : '0;
      penable_q <= nxt == ACCESS;
      hready_q  <= nxt == IDLE || nxt == ERR2;
      hresp_q   <= nxt == ERR1 || nxt == ERR2;
    end
endmodule
